ram_bus_ctrl: RTL



---
 rtl/ram_bus_ctrl_pkg.sv | 18 +
 rtl/ram_bus_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ram_bus_ctrl_pkg.sv
// Shared definitions for the CP/M-80 block-RAM bus controller.
// Holds the RAM geometry defaults and the controller state encoding.
package ram_bus_ctrl_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 8;
    localparam int RAM_DEPTH  = 16384;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD1   = 3'd1,
        ST_RD2   = 3'd2,
        ST_WR1   = 3'd3,
        ST_LOAD  = 3'd4,
        ST_LDEND = 3'd5
    } state_t;

endpackage

// File: rtl/ram_bus_ctrl.sv
// Sequences CPU read/write strobes and a streaming byte loader onto the single-port RAM.
// Reads ack 3 edges after the strobe, writes 2; loads run 1 byte/clock; busy callers are dropped.
module ram_bus_ctrl
    import ram_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ram_ce,
    output logic              ram_wre,
    output logic              ram_oce,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    state_t            state;
    logic              ld_pend;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] counter;
    logic [ADDR_W:0]   remain;

    assign ram_oce  = 1'b1;
    assign ld_ready = (state == ST_LOAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ld_pend   <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            counter   <= '0;
            remain    <= '0;
            cpu_busy  <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            ld_busy   <= 1'b0;
            ld_done   <= 1'b0;
            ram_ce    <= 1'b0;
            ram_wre   <= 1'b0;
            ram_ad    <= '0;
            ram_din   <= '0;
        end else begin
            cpu_ack <= 1'b0;
            ld_done <= 1'b0;

            // ld_busy covers both pending and running loads, so a repeat start is ignored
            if (ld_start && !ld_busy) begin
                base_q  <= ld_base;
                len_q   <= ld_len;
                ld_pend <= 1'b1;
                ld_busy <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        ram_ce   <= 1'b1;
                        ram_ad   <= cpu_addr;
                        cpu_busy <= 1'b1;
                        if (cpu_we) begin
                            ram_wre <= 1'b1;
                            ram_din <= cpu_wdata;
                            state   <= ST_WR1;
                        end else begin
                            ram_wre <= 1'b0;
                            state   <= ST_RD1;
                        end
                    end else if (ld_pend) begin
                        counter  <= base_q;
                        remain   <= len_q;
                        ld_pend  <= 1'b0;
                        cpu_busy <= 1'b1;
                        state    <= (len_q == '0) ? ST_LDEND : ST_LOAD;
                    end
                end
                ST_RD1: begin
                    ram_ce <= 1'b0;
                    state  <= ST_RD2;
                end
                ST_RD2: begin
                    cpu_rdata <= ram_dout;
                    cpu_ack   <= 1'b1;
                    cpu_busy  <= 1'b0;
                    state     <= ST_IDLE;
                end
                ST_WR1: begin
                    ram_ce   <= 1'b0;
                    ram_wre  <= 1'b0;
                    cpu_ack  <= 1'b1;
                    cpu_busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                ST_LOAD: begin
                    if (ld_valid) begin
                        ram_ce  <= 1'b1;
                        ram_wre <= 1'b1;
                        ram_ad  <= counter;
                        ram_din <= ld_data;
                        counter <= counter + 1'b1;
                        remain  <= remain - 1'b1;
                        if (remain == (ADDR_W+1)'(1)) begin
                            state <= ST_LDEND;
                        end
                    end else begin
                        ram_ce  <= 1'b0;
                        ram_wre <= 1'b0;
                    end
                end
                ST_LDEND: begin
                    ram_ce   <= 1'b0;
                    ram_wre  <= 1'b0;
                    ld_done  <= 1'b1;
                    ld_busy  <= 1'b0;
                    cpu_busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
